// File: rtl/vedic_product_accumulator.sv
// Frame accumulator for the registered Vedic multiplier product.
// Sums successive unsigned products into a saturating accumulator and
// presents each finished frame as a held result with a valid/ready handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ACC   | collecting terms; prod_ready high unless clear is asserted
//   HOLD  | frame result presented on sum/term_count/ovf; no terms taken
module vedic_product_accumulator #(
  parameter int PW        = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PW-1:0]    prod,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic [CW-1:0]    term_count,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CW-1:0]    tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic             close;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   t;
  logic             new_sat;
  logic [ACC_W-1:0] new_acc;

  // Accept arithmetic: one extra bit catches carry-out for saturation.
  always_comb begin
    prod_ready = (state_q == ACC) && !clear;
    accept     = prod_valid && prod_ready;
    base       = (cnt_q == '0) ? '0 : acc_q;
    t          = {1'b0, base} + {{(ACC_W + 1 - PW){1'b0}}, prod};
    new_sat    = t[ACC_W] || sat_q;
    new_acc    = new_sat ? {ACC_W{1'b1}} : t[ACC_W-1:0];
    close      = accept && (prod_last || (cnt_q == CW'(MAX_TERMS - 1)));
  end

  // Next-state logic: collect terms in ACC, present and handshake in HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    tc_d    = tc_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    case (state_q)
      ACC: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (close) begin
          sum_d   = new_acc;
          tc_d    = cnt_q + CW'(1);
          ovf_d   = new_sat;
          ov_d    = 1'b1;
          state_d = HOLD;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (accept) begin
          acc_d = new_acc;
          sat_d = new_sat;
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        // clear is deliberately ignored here so the pending result survives.
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and datapath registers; reset drops any partial or held frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      tc_q    <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end

  assign sum        = sum_q;
  assign term_count = tc_q;
  assign ovf        = ovf_q;
  assign out_valid  = ov_q;

endmodule
